// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block:
// region decode, register offsets and STATUS layout.
package data_mem_mmio_pkg;

  localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

  localparam logic [7:0] OFF_TXDATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_MTIME    = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP = 8'h0C;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 3;

  function automatic logic [31:0] status_word(
    input logic [7:0] cnt,
    input logic       ovf,
    input logic       full,
    input logic       empty
  );
    logic [31:0] s;
    s                      = '0;
    s[STAT_CNT_LSB +: 8]   = cnt;
    s[STAT_OVF]            = ovf;
    s[STAT_FULL]           = full;
    s[STAT_EMPTY]          = empty;
    return s;
  endfunction

endpackage

// File: rtl/data_mem_mmio_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, sync active-high reset.
// Ports: push/din in, pop in, head/full/empty/count out.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  // Head is forced to zero while empty; stale slots never leak out.
  assign head  = empty ? '0 : mem_q[rd_q];

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push & ~do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop & ~do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory for the RV32I core: word RAM plus MMIO TX FIFO and timer.
// Ports: core store/load (mem_write, addr, write_data, read_data), tx drain, timer_irq.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    ram_q [RAM_WORDS];
  logic [RAW-1:0] widx;
  logic           mmio;
  logic [7:0]     off;
  logic           unused_addr;

  logic           f_push, f_pop, f_full, f_empty;
  logic [FCW-1:0] f_cnt;
  logic           ovf_q, ovf_d;

  logic [31:0]    mtime_q, mtime_d;
  logic [31:0]    mtcmp_q, mtcmp_d;
  logic           irq_q;

  logic           wr_mmio;

  assign mmio        = (addr[31:16] == MMIO_BASE_HI);
  assign off         = addr[7:0];
  assign widx        = addr[RAW+1:2];
  assign unused_addr = ^{addr[15:8], addr[1:0]};
  assign wr_mmio     = mem_write & mmio;

  always_ff @(posedge clk) begin
    if (mem_write && !mmio && !reset) ram_q[widx] <= write_data;
  end

  assign f_push   = wr_mmio & (off == OFF_TXDATA);
  assign f_pop    = tx_valid & tx_ready;
  assign tx_valid = ~f_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .pop   (f_pop),
    .din   (write_data[7:0]),
    .head  (tx_data),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (wr_mmio && off == OFF_STATUS) ovf_d = 1'b0;
    else if (f_push && f_full && !f_pop) ovf_d = 1'b1;
  end

  always_comb begin
    mtime_d = mtime_q + 32'd1;
    mtcmp_d = mtcmp_q;
    if (wr_mmio && off == OFF_MTIME)    mtime_d = write_data;
    if (wr_mmio && off == OFF_MTIMECMP) mtcmp_d = write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      mtime_q <= '0;
      mtcmp_q <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      mtime_q <= mtime_d;
      mtcmp_q <= mtcmp_d;
      irq_q   <= (mtime_q >= mtcmp_q);
    end
  end

  assign timer_irq = irq_q;

  always_comb begin
    read_data = ram_q[widx];
    if (mmio) begin
      unique case (off)
        OFF_STATUS:   read_data = status_word(8'(f_cnt), ovf_q,
                                              f_full, f_empty);
        OFF_MTIME:    read_data = mtime_q;
        OFF_MTIMECMP: read_data = mtcmp_q;
        default:      read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: vector table for RAM/TX,
// hand sequences for overflow, full push+pop, timer wrap and reset.
module tb_data_mem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_MT  = 32'hFFFF_0008;
  localparam logic [31:0] A_MC  = 32'hFFFF_000C;

  always #5 clk = ~clk;

  data_mem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .timer_irq  (timer_irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic        ck;
    logic [31:0] rd;
    logic        v;
    logic [7:0]  d;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive, settle, caller checks, then next negedge.
  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    mem_write  = we;
    addr       = a;
    write_data = wd;
    tx_ready   = rdy;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] st(input int cnt, input logic ovf,
                                     input logic full, input logic emp);
    return (32'(cnt) << 3) | (32'(ovf) << 2) | (32'(full) << 1) | 32'(emp);
  endfunction

  initial begin
    vecs[0]  = '{1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 32'h10,  0, 0, 1, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{0, 32'h110, 0, 0, 1, 32'hDEADBEEF, 0, 0};
    vecs[3]  = '{1, 32'h110, 32'hCAFEF00D, 0, 1, 32'hDEADBEEF, 0, 0};
    vecs[4]  = '{0, 32'h10,  0, 0, 1, 32'hCAFEF00D, 0, 0};
    vecs[5]  = '{1, A_TX, 32'h41, 0, 1, 0, 0, 8'h00};
    vecs[6]  = '{1, A_TX, 32'h142, 0, 1, 0, 1, 8'h41};
    vecs[7]  = '{0, A_ST, 0, 0, 1, st(2,0,0,0), 1, 8'h41};
    vecs[8]  = '{0, A_ST, 0, 1, 1, st(2,0,0,0), 1, 8'h41};
    vecs[9]  = '{0, A_ST, 0, 1, 1, st(1,0,0,0), 1, 8'h42};
    vecs[10] = '{0, A_ST, 0, 0, 1, st(0,0,0,1), 0, 8'h00};

    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    // Reset state
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_irq", 32'(timer_irq), 0);
    drive(0, A_MC, 0, 0);
    chk("rst_mtcmp", read_data, 32'hFFFF_FFFF);
    reset = 1'b0;
    tick();

    // RAM + TX table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].rdy);
      if (vecs[i].ck) chk($sformatf("vec%0d_rd", i), read_data, vecs[i].rd);
      chk($sformatf("vec%0d_v", i), 32'(tx_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_d", i), 32'(tx_data), 32'(vecs[i].d));
      tick();
    end

    drive(0, 32'hFFFF_0010, 0, 0);
    chk("unmapped", read_data, 0);
    tick();

    // Overflow: 9 pushes, 9th dropped
    for (int i = 0; i < 9; i++) begin
      drive(1, A_TX, 32'h10 + 32'(i), 0);
      tick();
    end
    drive(0, A_ST, 0, 0);
    chk("ovf_status", read_data, st(8,1,1,0));
    chk("ovf_head", 32'(tx_data), 32'h10);
    tick();
    drive(1, A_ST, 0, 0);
    tick();
    drive(0, A_ST, 0, 0);
    chk("ovf_clr", read_data, st(8,0,1,0));
    tick();

    // Full + push + pop in the same cycle
    drive(1, A_TX, 32'hAA, 1);
    chk("fpp_head", 32'(tx_data), 32'h10);
    tick();
    drive(0, A_ST, 0, 1);
    chk("fpp_status", read_data, st(8,0,1,0));
    for (int i = 0; i < 8; i++) begin
      drive(0, A_ST, 0, 1);
      chk($sformatf("drain%0d", i), 32'(tx_data),
          (i == 7) ? 32'hAA : 32'h11 + 32'(i));
      tick();
    end
    drive(0, A_ST, 0, 0);
    chk("drain_empty", read_data, st(0,0,0,1));
    chk("drain_valid", 32'(tx_valid), 0);
    tick();

    // Timer wrap and compare
    drive(1, A_MC, 32'd5, 0);
    tick();
    drive(1, A_MT, 32'hFFFF_FFFE, 0);
    tick();
    drive(0, A_MT, 0, 0);
    chk("mt_fe", read_data, 32'hFFFF_FFFE);
    tick();
    drive(0, A_MT, 0, 0);
    chk("mt_ff", read_data, 32'hFFFF_FFFF);
    chk("irq_ff", 32'(timer_irq), 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, A_MT, 0, 0);
      chk($sformatf("mt_%0d", i), read_data, 32'(i));
      chk($sformatf("irq_%0d", i), 32'(timer_irq),
          32'((i == 0) || (i >= 6)));
      tick();
    end

    // Reset mid-drain with 3 bytes queued
    for (int i = 0; i < 3; i++) begin
      drive(1, A_TX, 32'h61 + 32'(i), 0);
      tick();
    end
    drive(0, A_ST, 0, 1);
    chk("pre_rst_head", 32'(tx_data), 32'h61);
    tick();
    reset = 1'b1;
    drive(1, 32'h10, 32'h55, 1);
    tick();
    reset = 1'b0;
    drive(0, A_ST, 0, 1);
    chk("rst2_valid", 32'(tx_valid), 0);
    chk("rst2_data", 32'(tx_data), 0);
    chk("rst2_status", read_data, st(0,0,0,1));
    chk("rst2_irq", 32'(timer_irq), 0);
    drive(0, A_MT, 0, 0);
    chk("rst2_mtime", read_data, 0);
    drive(0, 32'h10, 0, 0);
    chk("rst2_ram", read_data, 32'hCAFEF00D);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
